// File: rtl/serial_deser_stream.sv
// Parametrised bit-serial to parallel deserializer with valid/ready output, frame resync and overrun flags.
// Defining SERIAL_DESER_PARITY_EN appends one trailing parity bit per frame and drives out_perr.
module serial_deser_stream #(
  parameter int WIDTH      = 7,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          frame_sync,
  input  logic                          out_ready,
  input  logic                          ovf_clr,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  output logic                          out_perr,
  output logic                          ovf_pulse,
  output logic                          ovf_sticky,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH+2);
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int              FRAME_LEN = WIDTH + (PAR_EN ? 1 : 0);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(WIDTH);
  localparam logic            PAR_SENSE = (PARITY_ODD != 0);

  // Output register state; OUT_FULL is exactly out_valid.
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  out_state_t        r_state;
  out_state_t        w_state_next;
  logic [WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_data;
  logic              r_perr;
  logic              r_ovf_pulse;
  logic              r_ovf_sticky;

  logic [CNT_W-1:0]  w_cnt_base;
  logic [WIDTH-1:0]  w_shift_base;
  logic [WIDTH-1:0]  w_shift_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_is_par_bit;
  logic              w_complete;
  logic              w_perr_calc;
  logic              w_load;
  logic              w_drop;

  // Handshake: a word transfers on any rising edge where out_valid=1 and
  // out_ready=1; out_data/out_perr hold steady while out_valid=1 and no
  // transfer happens, and a completion on a transfer edge refills at once.
  always_comb begin
    w_cnt_base   = frame_sync ? '0 : r_cnt;
    w_shift_base = frame_sync ? '0 : r_shift;
    w_is_par_bit = PAR_EN && (w_cnt_base == PAR_IDX);
    w_shift_next = w_shift_base;
    if (in_valid && !w_is_par_bit) begin
      if (MSB_FIRST != 0) w_shift_next = {w_shift_base[WIDTH-2:0], in_bit};
      else                w_shift_next = {in_bit, w_shift_base[WIDTH-1:1]};
    end
    w_complete  = in_valid && (w_cnt_base == LAST_IDX);
    // In parity frames the completing bit is the parity bit itself.
    w_perr_calc = PAR_EN && ((^w_shift_next ^ in_bit) != PAR_SENSE);
    if (w_complete)    w_cnt_next = '0;
    else if (in_valid) w_cnt_next = w_cnt_base + CNT_W'(1);
    else               w_cnt_next = w_cnt_base;
    w_load = w_complete && ((r_state == OUT_EMPTY) || out_ready);
    w_drop = w_complete && (r_state == OUT_FULL) && !out_ready;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      OUT_EMPTY: if (w_load) w_state_next = OUT_FULL;
      OUT_FULL:  if (out_ready && !w_load) w_state_next = OUT_EMPTY;
      default:   w_state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= OUT_EMPTY;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_perr       <= 1'b0;
      r_ovf_pulse  <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_complete ? '0 : w_shift_next;
      r_cnt       <= w_cnt_next;
      r_ovf_pulse <= w_drop;
      if (w_load) begin
        r_data <= w_shift_next;
        r_perr <= w_perr_calc;
      end
      // A new overrun outranks a simultaneous clear.
      if (w_drop)       r_ovf_sticky <= 1'b1;
      else if (ovf_clr) r_ovf_sticky <= 1'b0;
    end
  end

  assign out_data   = r_data;
  assign out_valid  = (r_state == OUT_FULL);
  assign out_perr   = r_perr;
  assign ovf_pulse  = r_ovf_pulse;
  assign ovf_sticky = r_ovf_sticky;
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_serial_deser_stream.sv
// Testbench for serial_deser_stream: directed scenarios plus randomized traffic checked against a queue-based frame model.
module tb_serial_deser_stream;

  localparam int W     = 7;
  localparam int W8    = 8;
  localparam int CNT_W = $clog2(W+2);
  localparam int CNT8  = $clog2(W8+2);
  localparam bit PODD  = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL  = W + PAR;
  localparam int FL8 = W8 + PAR;

  logic clk;
  logic rst;
  logic in_valid, in_bit, frame_sync, out_ready, ovf_clr;
  logic [W-1:0] out_data;
  logic out_valid, out_perr, ovf_pulse, ovf_sticky;
  logic [CNT_W-1:0] bit_cnt;

  logic v8, b8, fs8, r8, clr8;
  logic [W8-1:0] od8;
  logic ov8, pe8, op8, os8;
  logic [CNT8-1:0] bc8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits of the current frame, held output words, overrun flags.
  bit           mq[$];
  logic [W-1:0] exp_q[$];
  bit           exp_pq[$];
  bit           exp_sticky;
  bit           exp_pulse;

  serial_deser_stream #(.WIDTH(W), .MSB_FIRST(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .frame_sync(frame_sync), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_perr(out_perr),
    .ovf_pulse(ovf_pulse), .ovf_sticky(ovf_sticky), .bit_cnt(bit_cnt)
  );

  serial_deser_stream #(.WIDTH(W8), .MSB_FIRST(0), .PARITY_ODD(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_bit(b8),
    .frame_sync(fs8), .out_ready(r8), .ovf_clr(clr8),
    .out_data(od8), .out_valid(ov8), .out_perr(pe8),
    .ovf_pulse(op8), .ovf_sticky(os8), .bit_cnt(bc8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit fbit(input logic [31:0] word, input int idx, input int width, input bit msb);
    if (idx < width) return msb ? word[width-1-idx] : word[idx];
    return (^word) ^ PODD;
  endfunction

  task automatic model_edge();
    logic [W-1:0] w;
    bit p;
    bit acc;
    if (!rst) begin
      mq.delete(); exp_q.delete(); exp_pq.delete();
      exp_sticky = 0; exp_pulse = 0;
      return;
    end
    exp_pulse = 0;
    acc = (exp_q.size() != 0) && out_ready;
    if (acc) begin
      void'(exp_q.pop_front());
      void'(exp_pq.pop_front());
    end
    if (frame_sync) mq.delete();
    if (in_valid) begin
      mq.push_back(in_bit);
      if (mq.size() == FL) begin
        w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = mq[i];
        p = (PAR == 1) ? (((^w) ^ mq[FL-1]) != PODD) : 1'b0;
        mq.delete();
        if (exp_q.size() == 0) begin
          exp_q.push_back(w);
          exp_pq.push_back(p);
        end else begin
          exp_pulse = 1;
        end
      end
    end
    if (exp_pulse)    exp_sticky = 1;
    else if (ovf_clr) exp_sticky = 0;
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] word, input int nbits, input bit bad_par);
    for (int idx = 0; idx < nbits; idx++) begin
      in_valid = 1'b1;
      in_bit   = fbit(32'(word), idx, W, 1'b1);
      if (idx == W && bad_par) in_bit = ~in_bit;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || bit_cnt !== '0 || out_perr !== 1'b0 ||
        ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b data=%h cnt=%0d perr=%b pulse=%b sticky=%b, expected all 0",
               out_valid, out_data, bit_cnt, out_perr, ovf_pulse, ovf_sticky);
    end
    n_checks++;
    if (ov8 !== 1'b0 || od8 !== '0 || bc8 !== '0) begin
      n_fail++;
      $display("FAIL reset8: valid=%b data=%h cnt=%0d, expected all 0", ov8, od8, bc8);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ascii_a();
    out_ready = 1'b1;
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      in_bit   = fbit(32'h41, i, W, 1'b1);
      tick();
      n_checks++;
      if (i < FL-1) begin
        if (out_valid !== 1'b0 || bit_cnt !== CNT_W'(i+1)) begin
          n_fail++;
          $display("FAIL ascii_a_bit%0d: valid=%b cnt=%0d, expected valid=0 cnt=%0d", i, out_valid, bit_cnt, i+1);
        end
      end else if (out_valid !== 1'b1 || out_data !== 7'h41 || bit_cnt !== '0 || out_perr !== 1'b0) begin
        n_fail++;
        $display("FAIL ascii_a_word: valid=%b data=%h cnt=%0d perr=%b, expected valid=1 data=41 cnt=0 perr=0",
                 out_valid, out_data, bit_cnt, out_perr);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ascii_a_accept: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_width8_lsb();
    int nv;
    nv = 0;
    for (int k = 0; k < 2*FL8-1; k++) begin
      v8 = (k % 2 == 0);
      b8 = fbit(32'h35, k/2, W8, 1'b0);
      if (v8) nv++;
      tick();
      n_checks++;
      if (bc8 !== CNT8'(nv % FL8)) begin
        n_fail++;
        $display("FAIL lsb8_cnt k=%0d: cnt=%0d, expected %0d", k, bc8, nv % FL8);
      end
    end
    v8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b1 || od8 !== 8'h35 || pe8 !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb8_word: valid=%b data=%h perr=%b, expected valid=1 data=35 perr=0", ov8, od8, pe8);
    end
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    send_word(7'h41, FL, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h41 || ovf_pulse !== 1'b0 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_first: valid=%b data=%h pulse=%b sticky=%b, expected 1 41 0 0", out_valid, out_data, ovf_pulse, ovf_sticky);
    end
    send_word(7'h42, FL, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h41 || ovf_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: valid=%b data=%h pulse=%b sticky=%b, expected 1 41 1 1", out_valid, out_data, ovf_pulse, ovf_sticky);
    end
    tick();
    n_checks++;
    if (ovf_pulse !== 1'b0 || ovf_sticky !== 1'b1 || out_data !== 7'h41) begin
      n_fail++;
      $display("FAIL ovf_hold: pulse=%b sticky=%b data=%h, expected 0 1 41", ovf_pulse, ovf_sticky, out_data);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_checks++;
    if (ovf_sticky !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear: sticky=%b valid=%b, expected 0 1", ovf_sticky, out_valid);
    end
    ovf_clr = 1'b1;
    send_word(7'h43, FL, 1'b0);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: pulse=%b sticky=%b, expected 1 1", ovf_pulse, ovf_sticky);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_release: valid=%b, expected 0", out_valid);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
  endtask

  task automatic test_frame_sync();
    out_ready = 1'b1;
    send_word(7'h7f, 3, 1'b0);
    frame_sync = 1'b1; in_valid = 1'b1; in_bit = fbit(32'h43, 0, W, 1'b1);
    tick();
    frame_sync = 1'b0;
    n_checks++;
    if (bit_cnt !== CNT_W'(1) || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_restart: cnt=%0d valid=%b, expected 1 0", bit_cnt, out_valid);
    end
    for (int i = 1; i < FL; i++) begin
      in_bit = fbit(32'h43, i, W, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h43) begin
      n_fail++;
      $display("FAIL sync_word: valid=%b data=%h, expected 1 43", out_valid, out_data);
    end
    tick();
    send_word(7'h55, FL-1, 1'b0);
    frame_sync = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    frame_sync = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || bit_cnt !== CNT_W'(1) || ovf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_at_complete: valid=%b cnt=%0d pulse=%b, expected 0 1 0", out_valid, bit_cnt, ovf_pulse);
    end
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    n_checks++;
    if (bit_cnt !== '0) begin
      n_fail++;
      $display("FAIL sync_idle: cnt=%0d, expected 0", bit_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b0;
    send_word(7'h41, FL, 1'b0);
    send_word(7'h42, FL, 1'b0);
    send_word(7'h7f, 3, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || bit_cnt !== '0 || ovf_sticky !== 1'b0 ||
        ovf_pulse !== 1'b0 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b data=%h cnt=%0d sticky=%b pulse=%b perr=%b, expected all 0",
               out_valid, out_data, bit_cnt, ovf_sticky, ovf_pulse, out_perr);
    end
    out_ready = 1'b1;
    send_word(7'h43, FL, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h43) begin
      n_fail++;
      $display("FAIL rst_mid_next: valid=%b data=%h, expected 1 43", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq [2];
    int nw;
    seq[0] = 7'h48; seq[1] = 7'h69;
    nw = 0;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < FL; i++) begin
        in_valid = (w < 2);
        in_bit   = (w < 2) ? fbit(32'(seq[w % 2]), i, W, 1'b1) : 1'b0;
        tick();
        if (out_valid === 1'b1) begin
          n_checks++;
          if (nw > 1 || out_data !== seq[nw % 2]) begin
            n_fail++;
            $display("FAIL b2b_word%0d: data=%h, expected %h", nw, out_data, seq[nw % 2]);
          end
          nw++;
        end
        if (ovf_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_pulse: pulse=%b, expected 0", ovf_pulse);
        end
      end
    end
    n_checks++;
    if (nw != 2) begin
      n_fail++;
      $display("FAIL b2b_count: words=%0d, expected 2", nw);
    end
    out_ready = 1'b0;
    send_word(7'h48, FL, 1'b0);
    send_word(7'h69, FL-1, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_bit = fbit(32'h69, FL-1, W, 1'b1);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h69 || ovf_pulse !== 1'b0 || ovf_sticky !== exp_sticky) begin
      n_fail++;
      $display("FAIL b2b_accept_complete: valid=%b data=%h pulse=%b sticky=%b, expected 1 69 0 %b",
               out_valid, out_data, ovf_pulse, ovf_sticky, exp_sticky);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b, expected 0", out_valid);
    end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    send_word(7'h41, FL, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h41 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_good: valid=%b data=%h perr=%b, expected 1 41 0", out_valid, out_data, out_perr);
    end
    send_word(7'h41, FL, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h41 || out_perr !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_bad: valid=%b data=%h perr=%b, expected 1 41 1", out_valid, out_data, out_perr);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 299) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_bit     = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 2) == 0);
      frame_sync = ($urandom_range(0, 29) == 0);
      ovf_clr    = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rand_valid c=%0d: valid=%b, expected %b", c, out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        n_checks++;
        if (out_data !== exp_q[0] || out_perr !== exp_pq[0]) begin
          n_fail++;
          $display("FAIL rand_data c=%0d: data=%h perr=%b, expected %h %b", c, out_data, out_perr, exp_q[0], exp_pq[0]);
        end
      end
      n_checks++;
      if (bit_cnt !== CNT_W'(mq.size())) begin
        n_fail++;
        $display("FAIL rand_cnt c=%0d: cnt=%0d, expected %0d", c, bit_cnt, mq.size());
      end
      n_checks++;
      if (ovf_pulse !== exp_pulse || ovf_sticky !== exp_sticky) begin
        n_fail++;
        $display("FAIL rand_ovf c=%0d: pulse=%b sticky=%b, expected %b %b", c, ovf_pulse, ovf_sticky, exp_pulse, exp_sticky);
      end
    end
    rst = 1'b1; in_valid = 1'b0; frame_sync = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; frame_sync = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    v8 = 1'b0; b8 = 1'b0; fs8 = 1'b0; r8 = 1'b1; clr8 = 1'b0;
    test_reset();
    test_ascii_a();
    test_width8_lsb();
    test_overrun();
    test_frame_sync();
    test_reset_midframe();
    test_back_to_back();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deser_stream.md
Name: serial_deser_stream

Overview:
- Parametrised serial-to-parallel deserializer; successor to the fixed 7-bit ASCII bit-collector.
- Sits between a bit-serial source (line decoder, shift-out of another block) and word-oriented consumers (character decoders, FIFOs).
- Adds programmable width, bit order, input qualifier, frame resync, valid/ready output handshake with overrun detection.

Parameters:
- WIDTH, 7, data bits per word (2..32)
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0]
- PARITY_ODD, 0, parity sense when SERIAL_DESER_PARITY_EN is defined (0 even, 1 odd); ignored otherwise

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  in_bit is sampled on this edge only when 1
- in_bit  in  1  serial data bit
- frame_sync  in  1  discard partial word; restart bit count at 0
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- ovf_clr  in  1  clears ovf_sticky
- out_data  out  WIDTH  assembled word, stable while out_valid=1
- out_valid  out  1  word available
- out_perr  out  1  parity error for current out_data
- ovf_pulse  out  1  one-cycle pulse: completed word dropped
- ovf_sticky  out  1  latched overrun status
- bit_cnt  out  $clog2(WIDTH+2)  bits collected in current frame

Behaviour:
- Reset (rst=0 at edge): shift reg, out_data, bit_cnt = 0; out_valid, out_perr, ovf_pulse, ovf_sticky = 0. Reset overrides all other inputs; mid-frame reset discards partial word.
- States: COLLECT (bit_cnt < FRAME_LEN), where FRAME_LEN = WIDTH (WIDTH+1 with parity). No idle state; collection always active.
- Edge with in_valid=1: bit shifted into shift reg per MSB_FIRST; bit_cnt += 1. in_valid=0: no change.
- Completion: edge at which bit_cnt==FRAME_LEN-1 and in_valid=1. bit_cnt returns to 0 on same edge; the next in_valid bit is bit 0 of next frame (no gap needed).
- Latency: word visible on out_data with out_valid=1 in the cycle after the completing edge.
- Handshake: out_valid holds, out_data stable, until edge with out_ready=1; then out_valid drops unless a completion occurs on the same edge.
- Simultaneous completion + accept (out_valid=1, out_ready=1): new word loaded, out_valid stays 1, no overrun.
- Overrun: completion while out_valid=1 and out_ready=0: new word dropped, held word kept, ovf_pulse=1 for one cycle, ovf_sticky set.
- ovf_clr=1 clears ovf_sticky; if set and clear on same edge, set wins.
- frame_sync=1: bit_cnt forced to 0, shift reg cleared; if in_valid=1 same edge, that bit is bit 0 of new frame (bit_cnt=1). Output register/handshake unaffected. frame_sync at completion edge: word discarded, no output.
- bit_cnt never exceeds FRAME_LEN-1 observable.

Optional Feature:
- Macro SERIAL_DESER_PARITY_EN.
- Defined: frame is WIDTH data bits plus one trailing parity bit (always last, regardless of MSB_FIRST). out_perr = 1 when XOR(data, parity bit) != PARITY_ODD; loaded/held with out_data; parity bit not in out_data.
- Undefined: frame is WIDTH bits; out_perr tied 0; PARITY_ODD unused.

Test Plan:
- WIDTH=7, MSB_FIRST=1, bits 1,0,0,0,0,0,1 with in_valid=1, out_ready=1 -> out_data=7'h41, out_valid high exactly one cycle after 7th edge.
- WIDTH=8, MSB_FIRST=0, bits of 0x35 LSB first, in_valid toggling 1/0 -> out_data=8'h35, bit_cnt only advancing on in_valid=1 edges.
- WIDTH=7, out_ready=0, send 'A' then 'B' back-to-back -> out_data stays 7'h41, ovf_pulse one cycle at 'B' completion, ovf_sticky=1 until ovf_clr; then out_ready=1 -> out_valid drops.
- Send 3 bits, pulse frame_sync, send 'C' (7'h43) -> out_data=7'h43, no spurious word; repeat with rst=0 mid-frame -> all outputs 0, next frame decoded correctly.
- Continuous stream 'H','i' with out_ready=1 each cycle -> two words, out_valid never gaps across accept+completion edge, no overrun.
- SERIAL_DESER_PARITY_EN, PARITY_ODD=0: 0x41 + parity 0 -> out_perr=0; 0x41 + parity 1 -> out_perr=1.
